// File: rtl/eqy_miter_seq_checker.sv
// Clocked miter consumer: compares gold/gate vectors under a care mask, counts samples/mismatches, captures the first miscompare.
// Optional toggle coverage outputs (seen0/seen1/cov_full) are built when EQY_MITER_TOGGLE_COV_EN is defined.
module eqy_miter_seq_checker #(
  parameter int WIDTH  = 1,
  parameter int WARMUP = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gold,
  input  logic [WIDTH-1:0] in_gate,
  input  logic [WIDTH-1:0] in_care,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [WIDTH-1:0] first_diff
`ifdef EQY_MITER_TOGGLE_COV_EN
  ,
  output logic [WIDTH-1:0] seen0,
  output logic [WIDTH-1:0] seen1,
  output logic             cov_full
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [7:0]       warm_q, warm_d;
  logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, mcnt_q, mcnt_d, fidx_q, fidx_d;
  logic [WIDTH-1:0] fdiff_q, fdiff_d;
  logic [WIDTH-1:0] diff_s;
`ifdef EQY_MITER_TOGGLE_COV_EN
  logic [WIDTH-1:0] seen0_q, seen0_d, seen1_q, seen1_d;
  logic             covf_q, covf_d;
`endif

  // Next-state and result update logic
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    fail_d  = fail_q;
    scnt_d  = scnt_q;
    mcnt_d  = mcnt_q;
    fidx_d  = fidx_q;
    fdiff_d = fdiff_q;
`ifdef EQY_MITER_TOGGLE_COV_EN
    seen0_d = seen0_q;
    seen1_d = seen1_q;
`endif
    diff_s  = (in_gold ^ in_gate) & in_care;

    if (start) begin
      fail_d  = 1'b0;
      scnt_d  = '0;
      mcnt_d  = '0;
      fidx_d  = '0;
      fdiff_d = '0;
      warm_d  = 8'd0;
`ifdef EQY_MITER_TOGGLE_COV_EN
      seen0_d = '0;
      seen1_d = '0;
`endif
      state_d = (WARMUP == 0) ? CHECK : WARM;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WARM: begin
          if (stop) begin
            state_d = DONE;
          end else if (in_valid) begin
            warm_d = warm_q + 8'd1;
            // The valid that brings the count to WARMUP is itself still discarded
            if (({1'b0, warm_q} + 9'd1) == 9'(WARMUP)) begin
              state_d = CHECK;
            end else begin
              state_d = WARM;
            end
          end else begin
            state_d = WARM;
          end
        end
        CHECK: begin
          if (in_valid) begin
            scnt_d = (&scnt_q) ? scnt_q : scnt_q + CNT_W'(1);
`ifdef EQY_MITER_TOGGLE_COV_EN
            seen0_d = seen0_q | (in_care & ~in_gold);
            seen1_d = seen1_q | (in_care & in_gold);
`endif
            if (diff_s != '0) begin
              mcnt_d = (&mcnt_q) ? mcnt_q : mcnt_q + CNT_W'(1);
              fail_d = 1'b1;
              if (!fail_q) begin
                fidx_d  = scnt_q;
                fdiff_d = diff_s;
              end else begin
                fidx_d  = fidx_q;
              end
            end else begin
              mcnt_d = mcnt_q;
            end
          end else begin
            scnt_d = scnt_q;
          end
          state_d = stop ? DONE : CHECK;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == WARM) || (state_d == CHECK);
    done_d = (state_d == DONE);
`ifdef EQY_MITER_TOGGLE_COV_EN
    covf_d = (&seen0_d) & (&seen1_d);
`endif
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      warm_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      scnt_q  <= '0;
      mcnt_q  <= '0;
      fidx_q  <= '0;
      fdiff_q <= '0;
`ifdef EQY_MITER_TOGGLE_COV_EN
      seen0_q <= '0;
      seen1_q <= '0;
      covf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      scnt_q  <= scnt_d;
      mcnt_q  <= mcnt_d;
      fidx_q  <= fidx_d;
      fdiff_q <= fdiff_d;
`ifdef EQY_MITER_TOGGLE_COV_EN
      seen0_q <= seen0_d;
      seen1_q <= seen1_d;
      covf_q  <= covf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign sample_cnt = scnt_q;
  assign mism_cnt   = mcnt_q;
  assign first_idx  = fidx_q;
  assign first_diff = fdiff_q;
`ifdef EQY_MITER_TOGGLE_COV_EN
  assign seen0    = seen0_q;
  assign seen1    = seen1_q;
  assign cov_full = covf_q;
`endif

endmodule

// File: tb/tb_eqy_miter_seq_checker.sv
// Directed table-driven bench for eqy_miter_seq_checker: instance A (WIDTH=8, WARMUP=2, CNT_W=16)
// runs a vector table; instance B (WARMUP=0, CNT_W=4) covers counter saturation by hand.
module tb_eqy_miter_seq_checker;

  typedef struct {
    logic       rst, start, stop, valid;
    logic [7:0] gold, gate, care;
    logic       busy, done, fail;
    logic [15:0] scnt, mcnt, fidx;
    logic [7:0] fdiff;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_stop, a_valid;
  logic [7:0]  a_gold, a_gate, a_care;
  logic        a_busy, a_done, a_fail;
  logic [15:0] a_scnt, a_mcnt, a_fidx;
  logic [7:0]  a_fdiff;

  logic        b_rst, b_start, b_stop, b_valid;
  logic [7:0]  b_gold, b_gate, b_care;
  logic        b_busy, b_done, b_fail;
  logic [3:0]  b_scnt, b_mcnt, b_fidx;
  logic [7:0]  b_fdiff;

`ifdef EQY_MITER_TOGGLE_COV_EN
  logic [7:0] a_seen0, a_seen1, b_seen0, b_seen1;
  logic       a_covf, b_covf;
`endif

  eqy_miter_seq_checker #(.WIDTH(8), .WARMUP(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop), .in_valid(a_valid),
    .in_gold(a_gold), .in_gate(a_gate), .in_care(a_care),
    .busy(a_busy), .done(a_done), .fail(a_fail), .sample_cnt(a_scnt), .mism_cnt(a_mcnt),
    .first_idx(a_fidx), .first_diff(a_fdiff)
`ifdef EQY_MITER_TOGGLE_COV_EN
    , .seen0(a_seen0), .seen1(a_seen1), .cov_full(a_covf)
`endif
  );

  eqy_miter_seq_checker #(.WIDTH(8), .WARMUP(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .in_valid(b_valid),
    .in_gold(b_gold), .in_gate(b_gate), .in_care(b_care),
    .busy(b_busy), .done(b_done), .fail(b_fail), .sample_cnt(b_scnt), .mism_cnt(b_mcnt),
    .first_idx(b_fidx), .first_diff(b_fdiff)
`ifdef EQY_MITER_TOGGLE_COV_EN
    , .seen0(b_seen0), .seen1(b_seen1), .cov_full(b_covf)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic p, input logic v,
                     input logic [7:0] g, input logic [7:0] t, input logic [7:0] c,
                     input logic eb, input logic ed, input logic ef,
                     input logic [15:0] es, input logic [15:0] em, input logic [15:0] ei,
                     input logic [7:0] edf);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.valid = v;
    x.gold = g; x.gate = t; x.care = c;
    x.busy = eb; x.done = ed; x.fail = ef;
    x.scnt = es; x.mcnt = em; x.fidx = ei; x.fdiff = edf;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_valid = 1'b0;
    a_gold = 8'h00; a_gate = 8'h00; a_care = 8'h00;
    b_rst = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_valid = 1'b0;
    b_gold = 8'h00; b_gate = 8'h00; b_care = 8'h00;

    //   rst  st   sp   vld  gold   gate   care   busy done fail  scnt    mcnt    fidx    fdiff
    add(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd1,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd2,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd3,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd4,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b1,1'b0,8'h5A,8'h5A,8'hFF, 1'b0,1'b1,1'b0, 16'd4,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h00,8'hFF, 1'b0,1'b1,1'b0, 16'd4,16'd0,16'd0,8'h00);
    // samples 3 and 5 after start mismatch on bit 1
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h58,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h58,8'hFF, 1'b1,1'b0,1'b1, 16'd1,16'd1,16'd0,8'h02);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,8'hFF, 1'b1,1'b0,1'b1, 16'd2,16'd1,16'd0,8'h02);
    add(1'b1,1'b0,1'b0,1'b1,8'h5A,8'h58,8'hFF, 1'b1,1'b0,1'b1, 16'd3,16'd2,16'd0,8'h02);
    add(1'b1,1'b0,1'b0,1'b0,8'h5A,8'h58,8'hFF, 1'b1,1'b0,1'b1, 16'd3,16'd2,16'd0,8'h02);
    // restart mid-CHECK with fail set, then don't-care masking
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h80,8'h00,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h80,8'h00,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h80,8'h00,8'h7F, 1'b1,1'b0,1'b0, 16'd1,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h80,8'h00,8'hFF, 1'b1,1'b0,1'b1, 16'd2,16'd1,16'd1,8'h80);
    add(1'b1,1'b0,1'b1,1'b1,8'h01,8'h00,8'hFF, 1'b0,1'b1,1'b1, 16'd3,16'd2,16'd1,8'h80);
    // start and stop together: start wins; then all-care-zero sample
    add(1'b1,1'b1,1'b1,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'hFF,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'hFF,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'hFF,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd1,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b1,1'b0,8'h00,8'h00,8'h00, 1'b0,1'b1,1'b0, 16'd1,16'd0,16'd0,8'h00);
    // stop during WARM
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b1,1'b0,8'h00,8'h00,8'h00, 1'b0,1'b1,1'b0, 16'd0,16'd0,16'd0,8'h00);
    // restart during WARM must clear the warmup count
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b1,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b1,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b1,1'b0,1'b1, 16'd1,16'd1,16'd0,8'h01);
    // reset together with start: reset wins, then idle ignores samples
    add(1'b0,1'b1,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b0,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);
    add(1'b1,1'b0,1'b0,1'b1,8'h01,8'h00,8'hFF, 1'b0,1'b0,1'b0, 16'd0,16'd0,16'd0,8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      a_rst = tbl[i].rst; a_start = tbl[i].start; a_stop = tbl[i].stop; a_valid = tbl[i].valid;
      a_gold = tbl[i].gold; a_gate = tbl[i].gate; a_care = tbl[i].care;
      tick();
      n_vec++;
      chk("busy",       i, {15'd0, a_busy}, {15'd0, tbl[i].busy});
      chk("done",       i, {15'd0, a_done}, {15'd0, tbl[i].done});
      chk("fail",       i, {15'd0, a_fail}, {15'd0, tbl[i].fail});
      chk("sample_cnt", i, a_scnt, tbl[i].scnt);
      chk("mism_cnt",   i, a_mcnt, tbl[i].mcnt);
      chk("first_idx",  i, a_fidx, tbl[i].fidx);
      chk("first_diff", i, {8'd0, a_fdiff}, {8'd0, tbl[i].fdiff});
    end
    a_start = 1'b0; a_stop = 1'b0; a_valid = 1'b0;

`ifdef EQY_MITER_TOGGLE_COV_EN
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_care = 8'hFF; a_gold = 8'h00; a_gate = 8'h00;
    tick(); tick();
    tick();
    n_vec++;
    chk("cov_partial", 100, {15'd0, a_covf}, 16'd0);
    chk("seen0_a",     100, {8'd0, a_seen0}, 16'h00FF);
    a_gold = 8'hFF; a_gate = 8'hFF;
    tick();
    n_vec++;
    chk("seen1_b",   101, {8'd0, a_seen1}, 16'h00FF);
    chk("cov_full",  101, {15'd0, a_covf}, 16'd1);
    a_valid = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    n_vec++;
    chk("seen_clear", 102, {a_seen0, a_seen1}, 16'h0000);
`endif

    // WARMUP=0, CNT_W=4: immediate CHECK and saturation
    tick();
    b_rst = 1'b1; b_start = 1'b1; tick(); b_start = 1'b0;
    n_vec++;
    chk("b_busy_start", 200, {15'd0, b_busy}, 16'd1);
    b_valid = 1'b1; b_gold = 8'h3C; b_gate = 8'h3C; b_care = 8'hFF;
    tick();
    n_vec++;
    chk("b_first_sample", 201, {12'd0, b_scnt}, 16'd1);
    for (int k = 1; k < 20; k++) tick();
    n_vec++;
    chk("b_sat_cnt",  202, {12'd0, b_scnt}, 16'd15);
    chk("b_sat_fail", 202, {15'd0, b_fail}, 16'd0);
    b_gold = 8'h0F; b_gate = 8'h00;
    tick();
    b_valid = 1'b0;
    n_vec++;
    chk("b_mism",  203, {12'd0, b_mcnt}, 16'd1);
    chk("b_fidx",  203, {12'd0, b_fidx}, 16'd15);
    chk("b_fdiff", 203, {8'd0, b_fdiff}, 16'h000F);
    chk("b_scnt",  203, {12'd0, b_scnt}, 16'd15);
    chk("b_fail",  203, {15'd0, b_fail}, 16'd1);
    tick();
    n_vec++;
    chk("b_hold", 204, {12'd0, b_scnt}, 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
